// File: rtl/saradc_11b_sar_ctrl.sv
// Successive-approximation control for the 11-bit SAR ADC: samples a channel, runs a
// 13-step redundant SAR search against the comparator and accumulates weighted result.
module saradc_11b_sar_ctrl #(
  parameter int N_CHANNELS = 14,
  parameter int SAR_MSB    = 12,
  parameter int RESULT_MSB = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [4:0]            chnr_i,
  input  logic                  st_ovr_en_i,
  input  logic [7:0]            st_ovr_i,
  input  logic                  abort_i,
  input  logic                  comp_i,
  output logic                  sample_o,
  output logic [SAR_MSB:0]      cap_set_o,
  output logic                  busy_o,
  output logic [RESULT_MSB:0]   result_o,
  output logic [4:0]            result_chnr_o,
  output logic                  result_valid_o,
  output logic                  err_inval_o
);

  localparam int W_SAR = SAR_MSB + 1;
  localparam int W_RES = RESULT_MSB + 1;
  localparam int BIT_W = $clog2(SAR_MSB + 1);

  // Product-level mask of channels that exist in the map but must not be converted.
  localparam logic [31:0] CH_INVALID_MASK = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [SAR_MSB:0]     sar_q;
  logic [RESULT_MSB:0]  acc_q;
  logic [4:0]           chnr_q;
  logic [RESULT_MSB:0]  result_q;
  logic [4:0]           result_chnr_q;
  logic                 err_q;

  logic                 ch_invalid;
  logic                 start_ok;
  logic [7:0]           st_load;
  logic [7:0]           st_load_eff;
  logic [SAR_MSB:0]     bit_mask;
  logic [RESULT_MSB:0]  acc_next;

  // Capacitor weight of each SAR step; the array is redundant so weights sum to 2048.
  function automatic logic [RESULT_MSB:0] cap_weight(input logic [BIT_W-1:0] idx);
    case (idx)
      4'd12:   cap_weight = W_RES'(824);
      4'd11:   cap_weight = W_RES'(496);
      4'd10:   cap_weight = W_RES'(296);
      4'd9:    cap_weight = W_RES'(176);
      4'd8:    cap_weight = W_RES'(108);
      4'd7:    cap_weight = W_RES'(64);
      4'd6:    cap_weight = W_RES'(36);
      4'd5:    cap_weight = W_RES'(22);
      4'd4:    cap_weight = W_RES'(12);
      4'd3:    cap_weight = W_RES'(7);
      4'd2:    cap_weight = W_RES'(4);
      4'd1:    cap_weight = W_RES'(2);
      4'd0:    cap_weight = W_RES'(1);
      default: cap_weight = '0;
    endcase
  endfunction

  function automatic logic [7:0] default_st(input logic [4:0] ch);
    default_st = (ch >= 5'd9) ? 8'd8 : 8'd1;
  endfunction

  assign ch_invalid  = (32'(chnr_i) >= N_CHANNELS) || CH_INVALID_MASK[chnr_i];
  assign start_ok    = start_i && !ch_invalid;
  assign st_load     = st_ovr_en_i ? st_ovr_i : default_st(chnr_i);
  assign st_load_eff = (st_load == 8'd0) ? 8'd1 : st_load;
  assign bit_mask    = W_SAR'(1) << bit_q;
  assign acc_next    = comp_i ? (acc_q + cap_weight(bit_q)) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SAMPLE;
      SAMPLE:  if (abort_i) state_d = IDLE;
               else if (cnt_q <= 8'd1) state_d = CONV;
      CONV:    if (abort_i) state_d = IDLE;
               else if (bit_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      bit_q         <= '0;
      sar_q         <= '0;
      acc_q         <= '0;
      chnr_q        <= '0;
      result_q      <= '0;
      result_chnr_q <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          err_q <= start_i && ch_invalid;
          if (start_ok) begin
            chnr_q <= chnr_i;
            cnt_q  <= st_load_eff;
            bit_q  <= BIT_W'(SAR_MSB);
            sar_q  <= '0;
            acc_q  <= '0;
          end
        end
        SAMPLE: begin
          if (abort_i)             cnt_q <= '0;
          else if (cnt_q > 8'd1)   cnt_q <= cnt_q - 8'd1;
        end
        CONV: begin
          if (abort_i) begin
            sar_q <= '0;
            acc_q <= '0;
          end else begin
            if (comp_i) sar_q <= sar_q | bit_mask;
            acc_q <= acc_next;
            // Result registers are loaded on the edge into DONE so they are valid with the pulse.
            if (bit_q == '0) begin
              result_q      <= acc_next;
              result_chnr_q <= chnr_q;
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end
        end
        DONE: begin
          sar_q <= '0;
          acc_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign sample_o       = (state_q == SAMPLE);
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == DONE);
  assign cap_set_o      = (state_q == CONV) ? (sar_q | bit_mask) : sar_q;
  assign result_o       = result_q;
  assign result_chnr_o  = result_chnr_q;
  assign err_inval_o    = err_q;

endmodule
